// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, filter length and parity helper.
package ps2_pkg;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FRAME_W    = BYTE_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RTS   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_ACK   = 3'd5
  } tx_state_e;

  // PS/2 frames carry odd parity over the data byte
  function automatic logic odd_parity(input logic [BYTE_W-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter on the raw PS/2 clock: level changes only after FILTER_LEN equal samples.
module ps2_clk_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ps2clk_in,
  output logic fall_edge
);

  logic [FILTER_LEN-1:0] shreg_q, shreg_d;
  logic                  f_q, f_d;
  logic                  fall_q, fall_d;

  always_comb begin
    shreg_d = {ps2clk_in, shreg_q[FILTER_LEN-1:1]};
    f_d     = f_q;
    if (&shreg_q) begin
      f_d = 1'b1;
    end else if (~|shreg_q) begin
      f_d = 1'b0;
    end
    fall_d = f_q & ~f_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      f_q     <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      f_q     <= f_d;
      fall_q  <= fall_d;
    end
  end

  assign fall_edge = fall_q;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, frame shift-out on device clock, ACK check, timeout.
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int unsigned RTS_CYCLES     = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_ps2,
  input  logic [BYTE_W-1:0] din,
  inout  wire               ps2clk,
  inout  wire               ps2data,
  output logic              tx_idle,
  output logic              tx_done_tick,
  output logic              tx_err
);

  localparam int unsigned RTS_W  = $clog2(RTS_CYCLES) + 1;
  localparam int unsigned TOUT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned BIT_W  = 4;

  tx_state_e            state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]     n_q, n_d;
  logic [RTS_W-1:0]     rts_cnt_q, rts_cnt_d;
  logic [TOUT_W-1:0]    tout_cnt_q, tout_cnt_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 clk_low, data_low;
  logic                 fall_edge;

  ps2_clk_filter u_clk_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2clk_in (ps2clk),
    .fall_edge (fall_edge)
  );

  // Open-drain drivers: lines are only ever pulled low or released
  assign ps2clk  = clk_low  ? 1'b0 : 1'bz;
  assign ps2data = data_low ? 1'b0 : 1'bz;

  assign tx_idle      = (state_q == ST_IDLE);
  assign tx_done_tick = done_q;
  assign tx_err       = err_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    n_d        = n_q;
    rts_cnt_d  = rts_cnt_q;
    tout_cnt_d = tout_cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    clk_low    = 1'b0;
    data_low   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_ps2) begin
          shift_d    = {odd_parity(din), din};
          err_d      = 1'b0;
          rts_cnt_d  = '0;
          tout_cnt_d = '0;
          state_d    = ST_RTS;
        end
      end
      ST_RTS: begin
        clk_low = 1'b1;
        if (rts_cnt_q == RTS_W'(RTS_CYCLES - 1)) begin
          rts_cnt_d  = '0;
          tout_cnt_d = '0;
          state_d    = ST_START;
        end else begin
          rts_cnt_d = rts_cnt_q + RTS_W'(1);
        end
      end
      ST_START: begin
        data_low = 1'b1;
        if (fall_edge) begin
          n_d     = BIT_W'(FRAME_W - 1);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        data_low = ~shift_q[0];
        if (fall_edge) begin
          shift_d = {1'b0, shift_q[FRAME_W-1:1]};
          if (n_q == '0) begin
            state_d = ST_STOP;
          end else begin
            n_d = n_q - BIT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (fall_edge) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (fall_edge) begin
          err_d   = ps2data;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Silent-device watchdog; wins over a coincident clock edge
    if (state_q inside {ST_START, ST_DATA, ST_STOP, ST_ACK}) begin
      if (tout_cnt_q == TOUT_W'(TIMEOUT_CYCLES - 1)) begin
        tout_cnt_d = '0;
        err_d      = 1'b1;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end else if (fall_edge) begin
        tout_cnt_d = '0;
      end else begin
        tout_cnt_d = tout_cnt_q + TOUT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      n_q        <= '0;
      rts_cnt_q  <= '0;
      tout_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      n_q        <= n_d;
      rts_cnt_q  <= rts_cnt_d;
      tout_cnt_q <= tout_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with a simple PS/2 keyboard model on open-drain lines.
module tb_ps2_transmitter;

  localparam int unsigned RTS  = 50;
  localparam int unsigned TOUT = 400;
  localparam int          HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx_idle, tx_done_tick, tx_err;
  wire        ps2clk, ps2data;

  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2data = dev_data_low ? 1'b0 : 1'bz;
  pullup (ps2clk);
  pullup (ps2data);

  ps2_transmitter #(
    .RTS_CYCLES     (RTS),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2clk       (ps2clk),
    .ps2data      (ps2data),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_err       (tx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;
  int rts_len;
  int low_len;
  logic [10:0] bits;

  always @(negedge clk) if (tx_done_tick) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue a write and measure the request-to-send low time
  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    din    = b;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    check("err_clr", 32'(tx_err), 32'd0);
    check("rts_data_z", 32'(ps2data), 32'd1);
    rts_len = 0;
    while (ps2clk === 1'b0 && rts_len < int'(RTS) + 100) begin
      rts_len++;
      @(negedge clk);
    end
    check("rts_len", 32'(rts_len), 32'(RTS));
    check("start_bit", 32'(ps2data), 32'd0);
  endtask

  // Keyboard model: n_edges clock pulses, samples data after each rising edge
  task automatic dev_frame(input int n_edges, input bit do_ack, input bit glitch,
                           output logic [10:0] smp);
    smp = '1;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 12 && do_ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (2) @(negedge clk);
      if (k <= 11) smp[k-1] = ps2data;
      if (glitch && k <= 8) begin
        repeat (4) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 9) @(negedge clk);
      end else begin
        repeat (HALF - 2) @(negedge clk);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic full_tx(input string tag, input logic [7:0] b, input bit do_ack,
                         input bit glitch, input logic [9:0] exp_bits, input bit exp_err);
    done_base = done_cnt;
    start_tx(b);
    repeat (16) @(negedge clk);
    dev_frame(12, do_ack, glitch, bits);
    repeat (5) @(negedge clk);
    check({tag, "_bits"}, 32'(bits[9:0]), 32'(exp_bits));
    check({tag, "_done"}, 32'(done_cnt - done_base), 32'd1);
    check({tag, "_err"}, 32'(tx_err), 32'(exp_err));
    check({tag, "_idle"}, 32'(tx_idle), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_idle", 32'(tx_idle), 32'd1);
    check("rst_err", 32'(tx_err), 32'd0);
    check("rst_done", 32'(tx_done_tick), 32'd0);
    check("rst_clk_z", 32'(ps2clk), 32'd1);
    check("rst_data_z", 32'(ps2data), 32'd1);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // 0xED: parity 1, ACK given
    full_tx("ed", 8'hED, 1'b1, 1'b0, 10'h3ED, 1'b0);
    // 0x00: parity 1 on the line
    full_tx("zero", 8'h00, 1'b1, 1'b0, 10'h300, 1'b0);

    // silent device: timeout while holding the start bit
    done_base = done_cnt;
    start_tx(8'h5A);
    low_len = 0;
    while (ps2data === 1'b0 && low_len < int'(TOUT) + 100) begin
      low_len++;
      @(negedge clk);
    end
    check("tout_len", 32'(low_len), 32'(TOUT));
    check("tout_err", 32'(tx_err), 32'd1);
    check("tout_idle", 32'(tx_idle), 32'd1);
    check("tout_clk_z", 32'(ps2clk), 32'd1);
    repeat (5) @(negedge clk);
    check("tout_done", 32'(done_cnt - done_base), 32'd1);

    // missing ACK
    full_tx("noack", 8'hC3, 1'b0, 1'b0, 10'h3C3, 1'b1);

    // second write mid-frame is ignored
    fork
      full_tx("ign", 8'hA6, 1'b1, 1'b0, 10'h3A6, 1'b0);
      begin
        repeat (200) @(negedge clk);
        din    = 8'h55;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
    join

    // short glitches on the clock must not cause extra shifts; parity 0 case
    full_tx("glitch", 8'h97, 1'b1, 1'b1, 10'h297, 1'b0);

    // reset in the middle of the data phase
    done_base = done_cnt;
    start_tx(8'h00);
    repeat (16) @(negedge clk);
    dev_frame(4, 1'b0, 1'b0, bits);
    check("mid_data_drv", 32'(ps2data), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_data_z", 32'(ps2data), 32'd1);
    check("mid_rst_clk_z", 32'(ps2clk), 32'd1);
    check("mid_rst_idle", 32'(tx_idle), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst_nodone", 32'(done_cnt - done_base), 32'd0);
    full_tx("after_rst", 8'hED, 1'b1, 1'b0, 10'h3ED, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
